complex_divider: RTL and testbench
==================================

Name: complex_divider

Overview:
- Sequential fixed-point complex divider; the inverse operation of the combinational complex multiplier.
- Computes (A + jB) / (C + jD) = ((AC + BD) + j(BC − AD)) / (C² + D²) on signed Q7.10 operands.
- Sits after the FFT magnitude/normalisation path, for equalisation and normalisation by a reference bin.
- Iterative restoring division with a Start/Busy/Done handshake; one operation in flight at a time.

Parameters:
WIDTH, 18, operand and result width, two's complement
FRAC, 10, fractional bits (1.0 = 2^FRAC = 1024)

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous, active-high reset
Start  input  1  request; sampled only while Busy=0
DinA  input  WIDTH  dividend real part
DinB  input  WIDTH  dividend imaginary part
DinC  input  WIDTH  divisor real part
DinD  input  WIDTH  divisor imaginary part
Busy  output  1  high from the edge after Start is accepted until the FIN edge
Done  output  1  one-cycle pulse; results valid
DoutR  output  WIDTH  quotient real part, held until the next Done
DoutI  output  WIDTH  quotient imaginary part, held until the next Done
DivZero  output  1  C=D=0 for the last result, held with the outputs
Sat  output  1  either part saturated for the last result, held with the outputs

Behaviour:
- Reset (async, Rst=1): state IDLE; Busy=0, Done=0, DoutR=0, DoutI=0, DivZero=0, Sat=0.
- Reset mid-operation: aborts immediately; no Done for the aborted operation.
- States and transitions:
  - IDLE: on Start=1, register DinA..DinD, go to MULT.
  - MULT (1 cycle): register signed NR = AC + BD and NI = BC − AD (2·WIDTH+1 bits), and unsigned DEN = C² + D².
    - Form |NR|, |NI| and signs.
    - Overflow precheck per part: |N|·2^FRAC ≥ DEN·2^(WIDTH−1) marks that part saturated.
    - Go to DIV.
  - DIV (WIDTH−1 = 17 cycles): one restoring-division step per cycle, MSB first, real and imaginary in parallel, sharing DEN.
    - Each part forms its quotient magnitude floor(|N|·2^FRAC / DEN).
  - FIN (1 cycle): apply sign (truncation toward zero), saturate, register outputs, Done=1, return to IDLE.
- Latency:
  - Start sampled at edge k.
  - Done high for exactly one cycle following edge k+19 (WIDTH+1).
  - Busy high for the cycles following edges k through k+18.
- Back-to-back: Busy=0 in the Done cycle, so Start in that cycle is accepted.
- Start while Busy=1: ignored; inputs not re-sampled.
- DinA..DinD are don't-care after the accepting edge.
- Saturation: a saturated part outputs +131071 (0x1FFFF) or −131071 (0x20001) per its sign; Sat=1. Symmetric, so −2^17 is never produced.
- Divide by zero (DEN=0):
  - DoutR=DoutI=0, DivZero=1, Sat=0.
  - Same latency; the DIV state still runs its full count.
- Zero numerator: result 0 with positive sign; never −0 artefacts.
- Flags and outputs update only at the FIN edge.

Test Plan:
1. A=2048, B=0, C=1024, D=0, Start one cycle -> Done exactly 19 cycles after the sampling edge; DoutR=2048, DoutI=0, Sat=0, DivZero=0.
2. (1+j)/(1−j): A=1024, B=1024, C=1024, D=0x3FC00 -> DoutR=0, DoutI=1024.
3. Truncation and sign:
   - A=1024, C=3072, B=D=0 -> DoutR=341.
   - Repeat with A=0x3FC00 -> DoutR=0x3FEAB (−341).
4. Saturation:
   - A=0x1FFFF, C=1, B=D=0 -> DoutR=0x1FFFF, Sat=1.
   - A=0x20001 -> DoutR=0x20001, Sat=1.
   - Next normal op (test 1) clears Sat.
5. Divide by zero: C=D=0, A=B=1024 -> DoutR=DoutI=0, DivZero=1, Done at cycle 19.
6. Handshake and reset:
   - Start pulsed at cycle 5 mid-operation -> ignored; single Done for the first op.
   - Start held high through Done -> second op accepted in the Done cycle.
   - Rst asserted at cycle 10 of an operation -> Busy=0 and outputs 0 immediately, no Done.
   - Fresh Start after reset completes correctly.

Source files
------------

// File: rtl/complex_divider_if.sv
// rtl/complex_divider_if.sv - start/busy/done handshake and operand/result bundle for complex_divider
interface complex_divider_if #(
    parameter int WIDTH = 18
);
    logic             Start;
    logic [WIDTH-1:0] DinA;
    logic [WIDTH-1:0] DinB;
    logic [WIDTH-1:0] DinC;
    logic [WIDTH-1:0] DinD;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] DoutR;
    logic [WIDTH-1:0] DoutI;
    logic             DivZero;
    logic             Sat;

    modport master (
        output Start, DinA, DinB, DinC, DinD,
        input  Busy, Done, DoutR, DoutI, DivZero, Sat
    );

    modport slave (
        input  Start, DinA, DinB, DinC, DinD,
        output Busy, Done, DoutR, DoutI, DivZero, Sat
    );
endinterface

// File: rtl/complex_divider.sv
// rtl/complex_divider.sv - sequential Q7.10 complex divider using restoring division
module complex_divider #(
    parameter int WIDTH = 18,
    parameter int FRAC  = 10
) (
    input  logic             Clk,
    input  logic             Rst,
    complex_divider_if.slave bus
);
    localparam int PW = 2 * WIDTH + 1;
    localparam int QW = WIDTH - 1;
    localparam int RW = PW + WIDTH - 2;
    localparam int SH = WIDTH - 1 - FRAC;
    localparam logic [4:0] LAST_STEP = 5'(QW - 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [RW-1:0]    rem_r_q, rem_r_d, rem_i_q, rem_i_d, den_sh_q, den_sh_d;
    logic [QW-1:0]    quo_r_q, quo_r_d, quo_i_q, quo_i_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             neg_r_q, neg_r_d, neg_i_q, neg_i_d;
    logic             ovf_r_q, ovf_r_d, ovf_i_q, ovf_i_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] dout_r_q, dout_r_d, dout_i_q, dout_i_d;
    logic             div_zero_q, div_zero_d, sat_q, sat_d;

    logic signed [PW-1:0] ax, bx, cx, dx, nr, ni;
    logic [PW-1:0]        den, mag_r, mag_i;
    logic                 ge_r, ge_i;

    // Symmetric saturation: the largest magnitude is 2^(WIDTH-1)-1 for either sign.
    function automatic logic [WIDTH-1:0] signed_result(input logic [QW-1:0] quo,
                                                       input logic neg, input logic ovf);
        logic [WIDTH-1:0] m;
        m = ovf ? {1'b0, {QW{1'b1}}} : {1'b0, quo};
        return neg ? -m : m;
    endfunction

    always_comb begin
        ax    = {{(PW-WIDTH){a_q[WIDTH-1]}}, a_q};
        bx    = {{(PW-WIDTH){b_q[WIDTH-1]}}, b_q};
        cx    = {{(PW-WIDTH){c_q[WIDTH-1]}}, c_q};
        dx    = {{(PW-WIDTH){d_q[WIDTH-1]}}, d_q};
        nr    = ax * cx + bx * dx;
        ni    = bx * cx - ax * dx;
        den   = cx * cx + dx * dx;
        mag_r = nr[PW-1] ? -nr : nr;
        mag_i = ni[PW-1] ? -ni : ni;
        ge_r  = rem_r_q >= den_sh_q;
        ge_i  = rem_i_q >= den_sh_q;
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        d_d        = d_q;
        rem_r_d    = rem_r_q;
        rem_i_d    = rem_i_q;
        den_sh_d   = den_sh_q;
        quo_r_d    = quo_r_q;
        quo_i_d    = quo_i_q;
        cnt_d      = cnt_q;
        neg_r_d    = neg_r_q;
        neg_i_d    = neg_i_q;
        ovf_r_d    = ovf_r_q;
        ovf_i_d    = ovf_i_q;
        dz_d       = dz_q;
        done_d     = 1'b0;
        dout_r_d   = dout_r_q;
        dout_i_d   = dout_i_q;
        div_zero_d = div_zero_q;
        sat_d      = sat_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    a_d     = bus.DinA;
                    b_d     = bus.DinB;
                    c_d     = bus.DinC;
                    d_d     = bus.DinD;
                    state_d = MULT;
                end
            end
            MULT: begin
                neg_r_d  = nr[PW-1];
                neg_i_d  = ni[PW-1];
                // Quotient would need WIDTH magnitude bits: |N|*2^FRAC >= DEN*2^(WIDTH-1)
                ovf_r_d  = {{SH{1'b0}}, mag_r} >= {den, {SH{1'b0}}};
                ovf_i_d  = {{SH{1'b0}}, mag_i} >= {den, {SH{1'b0}}};
                dz_d     = (den == '0);
                rem_r_d  = {{(RW-PW-FRAC){1'b0}}, mag_r, {FRAC{1'b0}}};
                rem_i_d  = {{(RW-PW-FRAC){1'b0}}, mag_i, {FRAC{1'b0}}};
                den_sh_d = {den, {(WIDTH-2){1'b0}}};
                quo_r_d  = '0;
                quo_i_d  = '0;
                cnt_d    = '0;
                state_d  = DIV;
            end
            DIV: begin
                if (ge_r) begin
                    rem_r_d = rem_r_q - den_sh_q;
                end
                if (ge_i) begin
                    rem_i_d = rem_i_q - den_sh_q;
                end
                quo_r_d  = {quo_r_q[QW-2:0], ge_r};
                quo_i_d  = {quo_i_q[QW-2:0], ge_i};
                den_sh_d = den_sh_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d     = 1'b1;
                dout_r_d   = dz_q ? '0 : signed_result(quo_r_q, neg_r_q, ovf_r_q);
                dout_i_d   = dz_q ? '0 : signed_result(quo_i_q, neg_i_q, ovf_i_q);
                div_zero_d = dz_q;
                sat_d      = !dz_q && (ovf_r_q || ovf_i_q);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            rem_r_q    <= '0;
            rem_i_q    <= '0;
            den_sh_q   <= '0;
            quo_r_q    <= '0;
            quo_i_q    <= '0;
            cnt_q      <= '0;
            neg_r_q    <= 1'b0;
            neg_i_q    <= 1'b0;
            ovf_r_q    <= 1'b0;
            ovf_i_q    <= 1'b0;
            dz_q       <= 1'b0;
            done_q     <= 1'b0;
            dout_r_q   <= '0;
            dout_i_q   <= '0;
            div_zero_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_q        <= d_d;
            rem_r_q    <= rem_r_d;
            rem_i_q    <= rem_i_d;
            den_sh_q   <= den_sh_d;
            quo_r_q    <= quo_r_d;
            quo_i_q    <= quo_i_d;
            cnt_q      <= cnt_d;
            neg_r_q    <= neg_r_d;
            neg_i_q    <= neg_i_d;
            ovf_r_q    <= ovf_r_d;
            ovf_i_q    <= ovf_i_d;
            dz_q       <= dz_d;
            done_q     <= done_d;
            dout_r_q   <= dout_r_d;
            dout_i_q   <= dout_i_d;
            div_zero_q <= div_zero_d;
            sat_q      <= sat_d;
        end
    end

    assign bus.Busy    = (state_q != IDLE);
    assign bus.Done    = done_q;
    assign bus.DoutR   = dout_r_q;
    assign bus.DoutI   = dout_i_q;
    assign bus.DivZero = div_zero_q;
    assign bus.Sat     = sat_q;
endmodule

// File: tb/tb_complex_divider.sv
// tb/tb_complex_divider.sv - directed vectors plus cycle-by-cycle arithmetic model for complex_divider
module tb_complex_divider;
    logic Clk;
    logic Rst;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    complex_divider_if #(.WIDTH(18)) bus ();

    complex_divider #(.WIDTH(18), .FRAC(10)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One part of the quotient: truncate toward zero, clamp magnitude at 2^17-1.
    function automatic longint part(input longint n, input longint den, output bit ovf);
        longint m, q;
        m   = (n < 0) ? -n : n;
        q   = (m * 1024) / den;
        ovf = (q > 131071);
        if (ovf) q = 131071;
        return (n < 0) ? -q : q;
    endfunction

    task automatic model(input logic [17:0] a, b, c, d,
                         output logic [17:0] r, i, output logic dz, sat);
        longint sa, sb, sc, sd, den, vr, vi;
        bit or_, oi;
        sa  = $signed(a);
        sb  = $signed(b);
        sc  = $signed(c);
        sd  = $signed(d);
        den = sc * sc + sd * sd;
        if (den == 0) begin
            r = '0; i = '0; dz = 1'b1; sat = 1'b0;
        end else begin
            vr  = part(sa * sc + sb * sd, den, or_);
            vi  = part(sb * sc - sa * sd, den, oi);
            r   = 18'(vr);
            i   = 18'(vi);
            dz  = 1'b0;
            sat = or_ | oi;
        end
    endtask

    bit          inflight = 0;
    int          acc = 0;
    logic [17:0] pr, pi, hr = '0, hi = '0;
    logic        pdz, psat, hdz = 1'b0, hsat = 1'b0;

    // Every falling edge: outputs must equal the model's held result; Busy/Done follow the accept edge.
    always @(negedge Clk) begin
        bit eb, ed;
        eb = 1'b0;
        ed = 1'b0;
        if (Rst) begin
            inflight = 0;
            hr = '0; hi = '0; hdz = 1'b0; hsat = 1'b0;
        end else begin
            eb = inflight && (cyc - acc) <= 18;
            ed = inflight && (cyc - acc) == 19;
            if (ed) begin
                hr = pr; hi = pi; hdz = pdz; hsat = psat;
                inflight = 0;
            end
        end
        chk("mon busy", 64'(bus.Busy), 64'(eb));
        chk("mon done", 64'(bus.Done), 64'(ed));
        chk("mon dout_r", 64'(bus.DoutR), 64'(hr));
        chk("mon dout_i", 64'(bus.DoutI), 64'(hi));
        chk("mon divzero", 64'(bus.DivZero), 64'(hdz));
        chk("mon sat", 64'(bus.Sat), 64'(hsat));
        if (!Rst && bus.Start && !eb) begin
            inflight = 1;
            acc = cyc + 1;
            model(bus.DinA, bus.DinB, bus.DinC, bus.DinD, pr, pi, pdz, psat);
        end
    end

    task automatic issue(input logic [17:0] a, b, c, d);
        @(posedge Clk); #2;
        bus.Start = 1'b1;
        bus.DinA = a; bus.DinB = b; bus.DinC = c; bus.DinD = d;
        @(posedge Clk); #2;
        bus.Start = 1'b0;
        bus.DinA = 18'($urandom); bus.DinB = 18'($urandom);
        bus.DinC = 18'($urandom); bus.DinD = 18'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge Clk); #2;
            n++;
        end while (!bus.Done && n < 40);
    endtask

    task automatic op(input string name, input logic [17:0] a, b, c, d,
                      input logic [17:0] er, ei, input logic edz, esat);
        int n;
        issue(a, b, c, d);
        wait_done(n);
        chk({name, " latency"}, 64'(n), 64'(19));
        chk({name, " dout_r"}, 64'(bus.DoutR), 64'(er));
        chk({name, " dout_i"}, 64'(bus.DoutI), 64'(ei));
        chk({name, " divzero"}, 64'(bus.DivZero), 64'(edz));
        chk({name, " sat"}, 64'(bus.Sat), 64'(esat));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ndone;
        logic [17:0] seen_r;
        Rst = 1'b1;
        bus.Start = 1'b0;
        bus.DinA = '0; bus.DinB = '0; bus.DinC = '0; bus.DinD = '0;
        repeat (3) @(posedge Clk);
        #2;
        chk("reset busy", 64'(bus.Busy), 64'(0));
        chk("reset done", 64'(bus.Done), 64'(0));
        chk("reset dout_r", 64'(bus.DoutR), 64'(0));
        chk("reset dout_i", 64'(bus.DoutI), 64'(0));
        Rst = 1'b0;

        op("t1 2/1", 18'd2048, 18'd0, 18'd1024, 18'd0, 18'd2048, 18'd0, 1'b0, 1'b0);
        op("t2 (1+j)/(1-j)", 18'd1024, 18'd1024, 18'd1024, 18'h3FC00, 18'd0, 18'd1024, 1'b0, 1'b0);
        op("t3 1/3", 18'd1024, 18'd0, 18'd3072, 18'd0, 18'd341, 18'd0, 1'b0, 1'b0);
        op("t3 -1/3", 18'h3FC00, 18'd0, 18'd3072, 18'd0, 18'h3FEAB, 18'd0, 1'b0, 1'b0);
        op("t4 sat pos", 18'h1FFFF, 18'd0, 18'd1, 18'd0, 18'h1FFFF, 18'd0, 1'b0, 1'b1);
        op("t4 sat neg", 18'h20001, 18'd0, 18'd1, 18'd0, 18'h20001, 18'd0, 1'b0, 1'b1);
        op("t4 sat clear", 18'd2048, 18'd0, 18'd1024, 18'd0, 18'd2048, 18'd0, 1'b0, 1'b0);
        op("t5 div zero", 18'd1024, 18'd1024, 18'd0, 18'd0, 18'd0, 18'd0, 1'b1, 1'b0);
        op("1/j", 18'd1024, 18'd0, 18'd0, 18'd1024, 18'd0, 18'h3FC00, 1'b0, 1'b0);
        op("zero num", 18'd0, 18'd0, 18'h3FB00, 18'd5, 18'd0, 18'd0, 1'b0, 1'b0);
        op("imag sat", 18'd0, 18'h20000, 18'd1, 18'd0, 18'd0, 18'h20001, 1'b0, 1'b1);

        // Start pulsed while busy must be ignored.
        issue(18'd2048, 18'd0, 18'd1024, 18'd0);
        repeat (4) @(posedge Clk);
        #2;
        bus.Start = 1'b1;
        bus.DinA = 18'd1024; bus.DinB = 18'd0; bus.DinC = 18'd3072; bus.DinD = 18'd0;
        @(posedge Clk); #2;
        bus.Start = 1'b0;
        ndone = 0;
        seen_r = '0;
        repeat (30) begin
            @(posedge Clk); #2;
            if (bus.Done) begin
                ndone++;
                seen_r = bus.DoutR;
            end
        end
        chk("ignored start done count", 64'(ndone), 64'(1));
        chk("ignored start dout_r", 64'(seen_r), 64'(2048));

        // Start held high: second op accepted in the Done cycle.
        @(posedge Clk); #2;
        bus.Start = 1'b1;
        bus.DinA = 18'd1024; bus.DinB = 18'd0; bus.DinC = 18'd3072; bus.DinD = 18'd0;
        wait_done(n);
        chk("held first latency", 64'(n), 64'(20));
        chk("held first dout_r", 64'(bus.DoutR), 64'(341));
        bus.DinA = 18'd2048; bus.DinC = 18'd1024;
        @(posedge Clk); #2;
        bus.Start = 1'b0;
        wait_done(n);
        chk("held second latency", 64'(n), 64'(19));
        chk("held second dout_r", 64'(bus.DoutR), 64'(2048));

        // Reset mid-operation aborts with no Done.
        issue(18'd1024, 18'd1024, 18'd1024, 18'h3FC00);
        repeat (8) @(posedge Clk);
        #2;
        Rst = 1'b1;
        #1;
        chk("abort busy", 64'(bus.Busy), 64'(0));
        chk("abort dout_r", 64'(bus.DoutR), 64'(0));
        repeat (2) @(posedge Clk);
        #2;
        Rst = 1'b0;
        ndone = 0;
        repeat (25) begin
            @(posedge Clk); #2;
            if (bus.Done) ndone++;
        end
        chk("abort done count", 64'(ndone), 64'(0));

        op("after reset", 18'd2048, 18'd0, 18'd1024, 18'd0, 18'd2048, 18'd0, 1'b0, 1'b0);

        repeat (3) @(posedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
